// File: rtl/reflet_dma.sv
// Single-channel word-copy DMA: stalls the CPU, copies CNT words SRC->DST with a
// read/latch/write sequence, then returns the bus and pulses irq.
module reflet_dma #(
  parameter int unsigned                  wordsize       = 16,
  parameter int unsigned                  base_addr_size = 15,
  parameter logic [base_addr_size-1:0]    base_addr      = 15'h7F40
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic [wordsize-1:0]       data_in,
  input  logic                      write_en,
  output logic [wordsize-1:0]       data_out,
  input  logic                      cpu_enable_in,
  output logic                      cpu_enable,
  output logic                      bus_owned,
  output logic [wordsize-1:0]       m_addr,
  output logic [wordsize-1:0]       m_data_out,
  output logic                      m_write_en,
  input  logic [wordsize-1:0]       m_data_in,
  output logic                      irq
);

  localparam int unsigned stride = wordsize / 8;
  localparam logic [base_addr_size-1:0] stride_a = base_addr_size'(stride);
  localparam logic [base_addr_size-1:0] span_a   = base_addr_size'(4 * stride);
  localparam logic [wordsize-1:0]       stride_w = wordsize'(stride);

  typedef enum logic [2:0] {
    IDLE, GRANT, READ, LATCH, WRITE, RELEASE
  } state_t;

  state_t state, state_next;

  logic [wordsize-1:0]       src, dst, cnt, buffer, rdata_q, rd_value;
  logic                      src_inc, dst_inc, done, zero_irq_q;
  logic [base_addr_size-1:0] rel;
  logic [1:0]                reg_idx;
  logic                      sel, reg_we, ctrl_start, start_go, zero_start;

  assign rel        = addr - base_addr;
  assign sel        = enable && (addr >= base_addr) && (rel < span_a);
  assign reg_idx    = 2'(rel / stride_a);
  assign reg_we     = sel && write_en && (state == IDLE);
  assign ctrl_start = reg_we && (reg_idx == 2'd3) && data_in[0];
  assign start_go   = ctrl_start && (cnt != '0);
  assign zero_start = ctrl_start && (cnt == '0);

  always_comb begin
    rd_value = '0;
    case (reg_idx)
      2'd0:    rd_value = src;
      2'd1:    rd_value = dst;
      2'd2:    rd_value = cnt;
      default: rd_value = wordsize'({done, 2'b00, state != IDLE});
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_go) state_next = GRANT;
      GRANT:   state_next = READ;
      READ:    state_next = LATCH;
      LATCH:   state_next = WRITE;
      WRITE:   state_next = (cnt == wordsize'(1)) ? RELEASE : READ;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RELEASE keeps the CPU stalled one extra cycle so synchronous memories can
  // refetch the CPU's address after the bus mux switches back.
  always_comb begin
    bus_owned  = 1'b0;
    m_addr     = '0;
    m_data_out = '0;
    m_write_en = 1'b0;
    case (state)
      GRANT, LATCH: bus_owned = 1'b1;
      READ: begin
        bus_owned = 1'b1;
        m_addr    = src;
      end
      WRITE: begin
        bus_owned  = 1'b1;
        m_addr     = dst;
        m_data_out = buffer;
        m_write_en = 1'b1;
      end
      default: ;
    endcase
    irq        = (state == RELEASE) || zero_irq_q;
    cpu_enable = cpu_enable_in && (state == IDLE);
    data_out   = bus_owned ? '0 : rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src        <= '0;
      dst        <= '0;
      cnt        <= '0;
      buffer     <= '0;
      rdata_q    <= '0;
      src_inc    <= 1'b0;
      dst_inc    <= 1'b0;
      done       <= 1'b0;
      zero_irq_q <= 1'b0;
    end else begin
      zero_irq_q <= zero_start;
      rdata_q    <= sel ? rd_value : '0;
      if (reg_we) begin
        case (reg_idx)
          2'd0: src <= data_in;
          2'd1: dst <= data_in;
          2'd2: cnt <= data_in;
          default: begin
            src_inc <= data_in[1];
            dst_inc <= data_in[2];
            done    <= zero_start;
          end
        endcase
      end
      if (state == LATCH) buffer <= m_data_in;
      if (state == WRITE) begin
        cnt <= cnt - wordsize'(1);
        if (src_inc) src <= src + stride_w;
        if (dst_inc) dst <= dst + stride_w;
      end
      if (state == RELEASE) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reflet_dma.sv
// Directed bench for reflet_dma with a 1-cycle synchronous RAM on the master bus.
module tb_reflet_dma;

  localparam logic [14:0] BASE = 15'h7F40;

  logic        clk = 1'b0;
  logic        reset, enable, write_en, cpu_enable_in;
  logic [14:0] addr;
  logic [15:0] data_in, data_out;
  logic        cpu_enable, bus_owned, m_write_en, irq;
  logic [15:0] m_addr, m_data_out, m_data_in;

  logic        tb_we;
  logic [15:0] tb_a, tb_d;
  logic [15:0] mem [0:32767];
  int          wr_count = 0;

  int n_err = 0;
  int n_checks = 0;

  reflet_dma #(.wordsize(16), .base_addr_size(15), .base_addr(15'h7F40)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .data_in(data_in),
    .write_en(write_en), .data_out(data_out), .cpu_enable_in(cpu_enable_in),
    .cpu_enable(cpu_enable), .bus_owned(bus_owned), .m_addr(m_addr),
    .m_data_out(m_data_out), .m_write_en(m_write_en), .m_data_in(m_data_in),
    .irq(irq)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (m_write_en)  mem[m_addr[15:1]] <= m_data_out;
    else if (tb_we)  mem[tb_a[15:1]]   <= tb_d;
    m_data_in <= mem[m_addr[15:1]];
    if (m_write_en) wr_count <= wr_count + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int unsigned idx, input logic [15:0] v);
    enable = 1'b1; write_en = 1'b1; addr = BASE + 15'(idx * 2); data_in = v;
    step(1);
    enable = 1'b0; write_en = 1'b0;
  endtask

  task automatic rd_addr(input logic [14:0] a, output logic [15:0] v);
    enable = 1'b1; write_en = 1'b0; addr = a;
    step(1);
    v = data_out;
    enable = 1'b0;
  endtask

  task automatic rd(input int unsigned idx, output logic [15:0] v);
    rd_addr(BASE + 15'(idx * 2), v);
  endtask

  task automatic mem_wr(input logic [15:0] a, input logic [15:0] d);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    step(1);
    tb_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    int          wc0;
    reset = 1'b1; enable = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
    cpu_enable_in = 1'b1; tb_we = 1'b0; tb_a = '0; tb_d = '0;
    step(3);
    check("rst_bus_owned", 16'(bus_owned), 16'h0);
    check("rst_cpu_enable", 16'(cpu_enable), 16'h1);
    reset = 1'b0;
    step(1);
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_m_addr", m_addr, 16'h0);
    check("rst_m_we", 16'(m_write_en), 16'h0);
    check("rst_data_out", data_out, 16'h0);
    rd(3, v); check("rst_ctrl", v, 16'h0);
    rd(0, v); check("rst_src", v, 16'h0);

    mem_wr(16'h8000, 16'h1111);
    mem_wr(16'h8002, 16'h2222);
    mem_wr(16'h8004, 16'h3333);
    mem_wr(16'h8006, 16'h4444);

    // Test 1: 4-word incrementing copy with exact cycle timing.
    wr(0, 16'h8000); wr(1, 16'h8100); wr(2, 16'h0004);
    wr(3, 16'h0007);
    for (int c = 1; c <= 16; c++) begin
      check("t1_bus_owned", 16'(bus_owned), 16'(c <= 13));
      check("t1_cpu_enable", 16'(cpu_enable), 16'(c >= 15));
      check("t1_irq", 16'(irq), 16'(c == 14));
      if (c == 4) begin
        check("t1_w0_we", 16'(m_write_en), 16'h1);
        check("t1_w0_addr", m_addr, 16'h8100);
        check("t1_w0_data", m_data_out, 16'h1111);
      end
      if (c == 13) begin
        check("t1_w3_addr", m_addr, 16'h8106);
        check("t1_w3_data", m_data_out, 16'h4444);
      end
      step(1);
    end
    check("t1_mem0", mem[16'h8100 >> 1], 16'h1111);
    check("t1_mem1", mem[16'h8102 >> 1], 16'h2222);
    check("t1_mem2", mem[16'h8104 >> 1], 16'h3333);
    check("t1_mem3", mem[16'h8106 >> 1], 16'h4444);
    rd(3, v); check("t1_ctrl", v, 16'h0008);
    step(1);
    check("t1_data_out_idle", data_out, 16'h0);

    // Test 2: fixed destination.
    wr(0, 16'h8000); wr(1, 16'h8200); wr(2, 16'h0003);
    wc0 = wr_count;
    wr(3, 16'h0003);
    step(12);
    check("t2_writes", 16'(wr_count - wc0), 16'd3);
    check("t2_mem", mem[16'h8200 >> 1], 16'h3333);
    rd(0, v); check("t2_src", v, 16'h8006);
    rd(1, v); check("t2_dst", v, 16'h8200);
    rd(2, v); check("t2_cnt", v, 16'h0000);
    rd_addr(BASE + 15'd3, v); check("t2_dst_odd_addr", v, 16'h8200);
    rd_addr(BASE + 15'd8, v); check("t2_out_of_range", v, 16'h0000);

    // Test 3: start with CNT=0.
    wr(2, 16'h0000);
    wr(3, 16'h0000);
    rd(3, v); check("t3_done_cleared", v, 16'h0000);
    wr(3, 16'h0001);
    check("t3_irq", 16'(irq), 16'h1);
    check("t3_bus_owned", 16'(bus_owned), 16'h0);
    check("t3_cpu_enable", 16'(cpu_enable), 16'h1);
    step(1);
    check("t3_irq_end", 16'(irq), 16'h0);
    check("t3_bus_owned2", 16'(bus_owned), 16'h0);
    rd(3, v); check("t3_ctrl", v, 16'h0008);

    // Test 4: source pointer wraps through 0xFFFE -> 0x0000.
    mem_wr(16'hFFFE, 16'hAAAA);
    mem_wr(16'h0000, 16'h5555);
    wr(0, 16'hFFFE); wr(1, 16'h9000); wr(2, 16'h0002);
    wr(3, 16'h0007);
    step(1);
    check("t4_read0_addr", m_addr, 16'hFFFE);
    step(3);
    check("t4_read1_addr", m_addr, 16'h0000);
    check("t4_read1_we", 16'(m_write_en), 16'h0);
    check("t4_read1_owned", 16'(bus_owned), 16'h1);
    step(4);
    check("t4_mem0", mem[16'h9000 >> 1], 16'hAAAA);
    check("t4_mem1", mem[16'h9002 >> 1], 16'h5555);
    rd(0, v); check("t4_src", v, 16'h0002);
    rd(1, v); check("t4_dst", v, 16'h9004);

    // Test 5a: CPU asleep throughout; stays asleep afterwards.
    cpu_enable_in = 1'b0;
    wr(0, 16'h8000); wr(1, 16'h8400); wr(2, 16'h0001);
    wr(3, 16'h0007);
    step(6);
    check("t5a_cpu_enable", 16'(cpu_enable), 16'h0);
    check("t5a_mem", mem[16'h8400 >> 1], 16'h1111);
    rd(3, v); check("t5a_ctrl", v, 16'h0008);

    // Test 5b: cpu_enable returns one cycle after bus_owned falls.
    cpu_enable_in = 1'b1;
    wr(1, 16'h8500); wr(2, 16'h0001);
    wr(3, 16'h0007);
    check("t5b_owned_t1", 16'(bus_owned), 16'h1);
    check("t5b_cpu_t1", 16'(cpu_enable), 16'h0);
    step(3);
    check("t5b_owned_t4", 16'(bus_owned), 16'h1);
    step(1);
    check("t5b_owned_t5", 16'(bus_owned), 16'h0);
    check("t5b_cpu_t5", 16'(cpu_enable), 16'h0);
    check("t5b_irq_t5", 16'(irq), 16'h1);
    step(1);
    check("t5b_cpu_t6", 16'(cpu_enable), 16'h1);
    check("t5b_irq_t6", 16'(irq), 16'h0);

    // Test 6: reset during WRITE of word 1 of 4.
    for (int i = 0; i < 4; i++) mem_wr(16'h8300 + 16'(2 * i), 16'hDEAD);
    wr(0, 16'h8000); wr(1, 16'h8300); wr(2, 16'h0004);
    wr(3, 16'h0007);
    step(6);
    check("t6_write1_we", 16'(m_write_en), 16'h1);
    check("t6_write1_addr", m_addr, 16'h8302);
    check("t6_write1_data", m_data_out, 16'h2222);
    reset = 1'b1;
    #1;
    check("t6_owned", 16'(bus_owned), 16'h0);
    check("t6_cpu_enable", 16'(cpu_enable), 16'h1);
    check("t6_we", 16'(m_write_en), 16'h0);
    check("t6_irq", 16'(irq), 16'h0);
    step(2);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t6_irq_after", 16'(irq), 16'h0);
      step(1);
    end
    check("t6_mem0", mem[16'h8300 >> 1], 16'h1111);
    check("t6_mem1", mem[16'h8302 >> 1], 16'hDEAD);
    rd(0, v); check("t6_src", v, 16'h0000);
    rd(1, v); check("t6_dst", v, 16'h0000);
    rd(2, v); check("t6_cnt", v, 16'h0000);
    rd(3, v); check("t6_ctrl", v, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
